dram_sequencer: RTL and testbench

//  Registered DRAM timing sequencer for the 8MB FastRAM array. It sits directly downstream of
//  the address-decode/autoconfig stage and consumes its decoded select, ram_sel. It drives the
//  row/column mux, RAS/CAS strobes, OE and WE for 68000 accesses. It also schedules
//  CAS-before-RAS refresh into idle bus time, using a refresh-debt counter.

---
 rtl/dram_sequencer.sv | 175 +++++++++++++++++
 tb/tb_dram_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dram_sequencer.sv
// DRAM timing sequencer for the FastRAM array: row/column mux, RAS/CAS/OE/WE
// strobes for 68000 accesses, and CAS-before-RAS refresh slotted into idle bus time.
module dram_sequencer #(
  parameter int unsigned REFRESH_INTERVAL = 110,
  parameter int unsigned MAX_DEBT         = 7,
  parameter int unsigned TRP              = 1
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        ASn,
  input  logic        UDSn,
  input  logic        LDSn,
  input  logic        RWn,
  input  logic        ram_sel,
  input  logic [22:1] ADDR,
  output logic [11:0] MADDR,
  output logic        RASn,
  output logic        UCASn,
  output logic        LCASn,
  output logic        OEn,
  output logic        MEMWn,
  output logic        refresh_pending,
  output logic        refresh_overrun
);

  localparam int unsigned CNT_W  = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int unsigned DEBT_W = $clog2(MAX_DEBT + 1);
  localparam int unsigned PRE_W  = (TRP > 1) ? $clog2(TRP) : 1;

  typedef enum logic [2:0] {
    IDLE, ROW, COL, CAS, REF_CAS, REF_RAS1, REF_RAS2, PRE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   int_cnt;
  logic [DEBT_W-1:0]  debt, debt_nxt;
  logic [PRE_W-1:0]   pre_cnt;
  logic [11:0]        maddr_nxt;
  logic               ras_nxt, ucas_nxt, lcas_nxt, oe_nxt, memw_nxt;
  logic               tc, ref_start, debt_max, overrun_set;

  logic [11:0] row_addr;
  logic [11:0] col_addr;
  assign row_addr = ADDR[22:11];
  assign col_addr = {2'b00, ADDR[10:1]};

  // Next state and next registered strobe/address values
  always_comb begin
    state_nxt = state;
    maddr_nxt = MADDR;
    ras_nxt   = 1'b1;
    ucas_nxt  = 1'b1;
    lcas_nxt  = 1'b1;
    oe_nxt    = 1'b1;
    memw_nxt  = 1'b1;
    case (state)
      IDLE: begin
        maddr_nxt = row_addr;
        if (!ASn && ram_sel) begin
          state_nxt = ROW;
          ras_nxt   = 1'b0;
        end else if (ASn && (debt != '0)) begin
          state_nxt = REF_CAS;
          ucas_nxt  = 1'b0;
          lcas_nxt  = 1'b0;
        end
      end
      ROW: begin
        if (ASn) begin
          state_nxt = PRE;
        end else begin
          state_nxt = COL;
          ras_nxt   = 1'b0;
          maddr_nxt = col_addr;
        end
      end
      COL: begin
        if (ASn) begin
          state_nxt = PRE;
        end else begin
          ras_nxt = 1'b0;
          if (!UDSn || !LDSn) begin
            state_nxt = CAS;
            ucas_nxt  = UDSn;
            lcas_nxt  = LDSn;
            oe_nxt    = !RWn;
            memw_nxt  = RWn;
          end
        end
      end
      CAS: begin
        if (ASn) begin
          state_nxt = PRE;
        end else begin
          ras_nxt  = 1'b0;
          ucas_nxt = UCASn;
          lcas_nxt = LCASn;
          oe_nxt   = OEn;
          memw_nxt = MEMWn;
        end
      end
      REF_CAS: begin
        state_nxt = REF_RAS1;
        ras_nxt   = 1'b0;
        ucas_nxt  = 1'b0;
        lcas_nxt  = 1'b0;
      end
      REF_RAS1: begin
        state_nxt = REF_RAS2;
        ras_nxt   = 1'b0;
        ucas_nxt  = 1'b0;
        lcas_nxt  = 1'b0;
      end
      REF_RAS2: begin
        state_nxt = PRE;
      end
      PRE: begin
        maddr_nxt = row_addr;
        if (pre_cnt == PRE_W'(TRP - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and strobe registers; strobes drop to inactive the moment reset asserts
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
      MADDR <= '0;
      RASn  <= 1'b1;
      UCASn <= 1'b1;
      LCASn <= 1'b1;
      OEn   <= 1'b1;
      MEMWn <= 1'b1;
    end else begin
      state <= state_nxt;
      MADDR <= maddr_nxt;
      RASn  <= ras_nxt;
      UCASn <= ucas_nxt;
      LCASn <= lcas_nxt;
      OEn   <= oe_nxt;
      MEMWn <= memw_nxt;
    end
  end

  assign tc          = (int_cnt == CNT_W'(REFRESH_INTERVAL - 1));
  assign ref_start   = (state == IDLE) && (state_nxt == REF_CAS);
  assign debt_max    = (debt == DEBT_W'(MAX_DEBT));
  assign overrun_set = tc && debt_max && !ref_start;

  // Refresh debt: credit at terminal count, debit on each refresh start
  always_comb begin
    debt_nxt = debt;
    if (tc && !ref_start && !debt_max) debt_nxt = debt + DEBT_W'(1);
    else if (!tc && ref_start)         debt_nxt = debt - DEBT_W'(1);
  end

  // Interval, debt, precharge counters and refresh status flags
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      int_cnt         <= '0;
      debt            <= '0;
      pre_cnt         <= '0;
      refresh_pending <= 1'b0;
      refresh_overrun <= 1'b0;
    end else begin
      int_cnt         <= tc ? '0 : int_cnt + CNT_W'(1);
      debt            <= debt_nxt;
      pre_cnt         <= (state == PRE) ? pre_cnt + PRE_W'(1) : '0;
      refresh_pending <= (debt_nxt != '0);
      if (overrun_set) refresh_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_sequencer.sv
// Directed bench for dram_sequencer with an 8-cycle refresh interval.
module tb_dram_sequencer;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        ASn = 1'b1;
  logic        UDSn = 1'b1;
  logic        LDSn = 1'b1;
  logic        RWn = 1'b1;
  logic        ram_sel = 1'b0;
  logic [22:1] ADDR = '0;
  logic [11:0] MADDR;
  logic        RASn, UCASn, LCASn, OEn, MEMWn;
  logic        refresh_pending, refresh_overrun;
  logic [4:0]  strb;

  int n_checks = 0;
  int n_pass   = 0;
  int hit      = 0;
  int refs     = 0;

  dram_sequencer #(.REFRESH_INTERVAL(8), .MAX_DEBT(7), .TRP(1)) dut (
    .CLK(CLK), .RESETn(RESETn), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RWn(RWn),
    .ram_sel(ram_sel), .ADDR(ADDR), .MADDR(MADDR), .RASn(RASn), .UCASn(UCASn),
    .LCASn(LCASn), .OEn(OEn), .MEMWn(MEMWn),
    .refresh_pending(refresh_pending), .refresh_overrun(refresh_overrun)
  );

  always #5 CLK = ~CLK;

  // strobe vector order: RASn, UCASn, LCASn, OEn, MEMWn
  assign strb = {RASn, UCASn, LCASn, OEn, MEMWn};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Idle inputs, hold reset two edges, release just after an edge (edge 1 is the next one)
  task automatic do_reset();
    RESETn  = 1'b0;
    ASn     = 1'b1;
    UDSn    = 1'b1;
    LDSn    = 1'b1;
    RWn     = 1'b1;
    ram_sel = 1'b1;
    ADDR    = '0;
    tick(2);
    RESETn = 1'b1;
  endtask

  initial begin
    // Reset asserted in the middle of a CAS cycle
    do_reset();
    chk("rst_strb", 32'(strb), 32'h1f);
    chk("rst_maddr", 32'(MADDR), 32'h0);
    ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0; RWn = 1'b1; ADDR = 22'h12_3456;
    tick(10);
    chk("t1_cas_active", 32'(strb), 32'h01);
    chk("t1_pending_before", 32'(refresh_pending), 32'h1);
    #2 RESETn = 1'b0;
    #1;
    chk("t1_rst_strb", 32'(strb), 32'h1f);
    chk("t1_rst_maddr", 32'(MADDR), 32'h0);
    chk("t1_rst_pending", 32'(refresh_pending), 32'h0);
    chk("t1_rst_overrun", 32'(refresh_overrun), 32'h0);

    // Word read
    do_reset();
    ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0; RWn = 1'b1; ADDR = 22'h12_3456;
    tick(1);
    chk("t2_row_strb", 32'(strb), 32'h0f);
    chk("t2_row_maddr", 32'(MADDR), 32'h48d);
    tick(1);
    chk("t2_col_strb", 32'(strb), 32'h0f);
    chk("t2_col_maddr", 32'(MADDR), 32'h056);
    tick(1);
    chk("t2_cas_strb", 32'(strb), 32'h01);
    tick(2);
    chk("t2_cas_hold", 32'(strb), 32'h01);
    chk("t2_cas_maddr", 32'(MADDR), 32'h056);
    ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    tick(1);
    chk("t2_release", 32'(strb), 32'h1f);

    // Lower byte write with late data strobe
    do_reset();
    ASn = 1'b0; RWn = 1'b0; ADDR = 22'h2A_BCDE;
    tick(1);
    chk("t3_row_maddr", 32'(MADDR), 32'haaf);
    tick(1);
    chk("t3_col_maddr", 32'(MADDR), 32'h0de);
    chk("t3_col1_strb", 32'(strb), 32'h0f);
    tick(1);
    chk("t3_col2_strb", 32'(strb), 32'h0f);
    LDSn = 1'b0;
    tick(1);
    chk("t3_cas_strb", 32'(strb), 32'h0a);
    tick(1);
    chk("t3_cas_hold", 32'(strb), 32'h0a);
    ASn = 1'b1; LDSn = 1'b1; RWn = 1'b1;
    tick(1);
    chk("t3_release", 32'(strb), 32'h1f);

    // Idle bus: periodic CBR refresh
    do_reset();
    tick(7);
    chk("t4_pending_e7", 32'(refresh_pending), 32'h0);
    tick(1);
    chk("t4_pending_e8", 32'(refresh_pending), 32'h1);
    chk("t4_idle_e8", 32'(strb), 32'h1f);
    tick(1);
    chk("t4_ref_cas", 32'(strb), 32'h13);
    chk("t4_pending_e9", 32'(refresh_pending), 32'h0);
    tick(1);
    chk("t4_ref_ras1", 32'(strb), 32'h03);
    tick(1);
    chk("t4_ref_ras2", 32'(strb), 32'h03);
    tick(1);
    chk("t4_pre", 32'(strb), 32'h1f);
    tick(1);
    chk("t4_idle", 32'(strb), 32'h1f);
    tick(4);
    chk("t4_ref2_cas", 32'(strb), 32'h13);
    tick(1);
    chk("t4_ref2_ras", 32'(strb), 32'h03);

    // Long access: debt saturates, overrun latches, then refresh drains the debt
    do_reset();
    ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0; RWn = 1'b1; ADDR = 22'h00_0400;
    tick(63);
    chk("t5_overrun_e63", 32'(refresh_overrun), 32'h0);
    chk("t5_pending_e63", 32'(refresh_pending), 32'h1);
    tick(1);
    chk("t5_overrun_e64", 32'(refresh_overrun), 32'h1);
    tick(6);
    chk("t5_cas_e70", 32'(strb), 32'h01);
    ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    for (int k = 71; k <= 270; k++) begin
      tick(1);
      if (strb == 5'h13) refs++;
      if (!refresh_pending) begin
        hit = k;
        break;
      end
    end
    chk("t5_drain_edge", 32'(hit), 32'd143);
    chk("t5_refresh_count", 32'(refs), 32'd15);
    chk("t5_overrun_sticky", 32'(refresh_overrun), 32'h1);

    // ram_sel gating, then access beats pending refresh and aborts in ROW
    do_reset();
    ram_sel = 1'b0; ASn = 1'b0; ADDR = 22'h3F_F800;
    tick(1);
    chk("t6_nosel_strb", 32'(strb), 32'h1f);
    chk("t6_nosel_maddr", 32'(MADDR), 32'hffe);
    tick(7);
    chk("t6_nosel_e8", 32'(strb), 32'h1f);
    chk("t6_pending_e8", 32'(refresh_pending), 32'h1);
    ram_sel = 1'b1;
    tick(1);
    chk("t6_row_wins", 32'(strb), 32'h0f);
    chk("t6_pending_row", 32'(refresh_pending), 32'h1);
    ASn = 1'b1;
    tick(1);
    chk("t6_abort_pre", 32'(strb), 32'h1f);
    tick(1);
    chk("t6_idle", 32'(strb), 32'h1f);
    tick(1);
    chk("t6_ref_cas", 32'(strb), 32'h13);
    chk("t6_pending_cleared", 32'(refresh_pending), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
